// File: rtl/pr_free_list.sv
// Physical-register free list: 128-entry circular buffer of PR tags with
// 2-wide allocate, 2-wide retire return, and recovery to the retire point.
module pr_free_list (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] id_dispatch_num,
    input  logic       id_valid_inst0,
    input  logic       id_valid_inst1,
    input  logic [1:0] rob_retire_num,
    input  logic [6:0] rob_retire_told0,
    input  logic [6:0] rob_retire_told1,
    input  logic       recover,
    output logic [6:0] fl_pr0,
    output logic [6:0] fl_pr1,
    output logic [1:0] fl_avail_num,
    output logic [7:0] fl_count,
    output logic       fl_error
);

    logic [6:0] mem_q [128];
    logic [6:0] head_q, head_d;
    logic [6:0] tail_q, tail_d;
    logic [6:0] retire_head_q, retire_head_d;
    logic [7:0] count_q, count_d;
    logic       fl_error_q, fl_error_d;

    logic [1:0] pop_req, pop_eff, push_eff;
    logic [8:0] cnt_sum;
    logic       wr_en0, wr_en1;

    // Offers come straight from the buffer; tags written this cycle only
    // become visible after the edge.
    assign fl_pr0       = mem_q[head_q];
    assign fl_pr1       = id_valid_inst0 ? mem_q[head_q + 7'd1] : mem_q[head_q];
    assign fl_avail_num = (count_q >= 8'd2) ? 2'd2 : count_q[1:0];
    assign fl_count     = count_q;
    assign fl_error     = fl_error_q;

    always_comb begin
        pop_req       = {1'b0, (id_dispatch_num >= 2'd1) && id_valid_inst0}
                      + {1'b0, (id_dispatch_num == 2'd2) && id_valid_inst1};
        pop_eff       = pop_req;
        push_eff      = rob_retire_num;
        head_d        = head_q;
        tail_d        = tail_q;
        retire_head_d = retire_head_q;
        count_d       = count_q;
        fl_error_d    = fl_error_q;
        wr_en0        = 1'b0;
        wr_en1        = 1'b0;
        cnt_sum       = 9'd0;

        if (recover) begin
            head_d  = retire_head_q;
            count_d = 8'd96;
        end else begin
            if ({6'd0, pop_req} > count_q) begin
                pop_eff    = count_q[1:0];
                fl_error_d = 1'b1;
            end
            cnt_sum = {1'b0, count_q} + {7'd0, push_eff} - {7'd0, pop_eff};
            // Overflow drops the whole return; retire bookkeeping still moves.
            if (cnt_sum > 9'd128) begin
                push_eff   = 2'd0;
                fl_error_d = 1'b1;
            end
            wr_en0        = push_eff >= 2'd1;
            wr_en1        = push_eff == 2'd2;
            head_d        = head_q + {5'd0, pop_eff};
            tail_d        = tail_q + {5'd0, push_eff};
            retire_head_d = retire_head_q + {5'd0, rob_retire_num};
            count_d       = count_q + {6'd0, push_eff} - {6'd0, pop_eff};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q        <= 7'd0;
            tail_q        <= 7'd96;
            retire_head_q <= 7'd0;
            count_q       <= 8'd96;
            fl_error_q    <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            retire_head_q <= retire_head_d;
            count_q       <= count_d;
            fl_error_q    <= fl_error_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 128; i++)
                mem_q[i] <= (i < 96) ? 7'(32 + i) : 7'd0;
        end else begin
            if (wr_en0) mem_q[tail_q] <= rob_retire_told0;
            if (wr_en1) mem_q[tail_q + 7'd1] <= rob_retire_told1;
        end
    end

endmodule

// File: tb/tb_pr_free_list.sv
// Bench for pr_free_list: directed vector table, corner sequences, and
// randomized traffic against a queue-based free/in-flight tag model.
module tb_pr_free_list;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] id_dispatch_num;
    logic       id_valid_inst0, id_valid_inst1;
    logic [1:0] rob_retire_num;
    logic [6:0] rob_retire_told0, rob_retire_told1;
    logic       recover;
    logic [6:0] fl_pr0, fl_pr1;
    logic [1:0] fl_avail_num;
    logic [7:0] fl_count;
    logic       fl_error;

    pr_free_list dut (
        .clock(clock), .reset(reset),
        .id_dispatch_num(id_dispatch_num),
        .id_valid_inst0(id_valid_inst0), .id_valid_inst1(id_valid_inst1),
        .rob_retire_num(rob_retire_num),
        .rob_retire_told0(rob_retire_told0), .rob_retire_told1(rob_retire_told1),
        .recover(recover),
        .fl_pr0(fl_pr0), .fl_pr1(fl_pr1), .fl_avail_num(fl_avail_num),
        .fl_count(fl_count), .fl_error(fl_error)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input int n, input bit v0, input bit v1, input int rn,
                         input int t0, input int t1, input bit rec);
        id_dispatch_num  = 2'(n);
        id_valid_inst0   = v0;
        id_valid_inst1   = v1;
        rob_retire_num   = 2'(rn);
        rob_retire_told0 = 7'(t0);
        rob_retire_told1 = 7'(t1);
        recover          = rec;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 1, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        int n; bit v0; bit v1; int rn; int t0; int t1; bit rec;
        int e_pr0; int e_pr1; int e_avail; int e_count;
    } vec_t;

    // Model: free tags in offer order, and allocated-but-unretired tags.
    int fq[$];
    int inflight[$];

    task automatic model_reset();
        fq.delete();
        inflight.delete();
        for (int i = 0; i < 96; i++) fq.push_back(32 + i);
    endtask

    task automatic model_cycle(input int n, input bit v0, input bit v1, input int rn,
                               input bit rec, input string tag);
        int pop, t0, t1;
        pop = ((n >= 1 && v0) ? 1 : 0) + ((n == 2 && v1) ? 1 : 0);
        t0 = (rn >= 1) ? inflight[0] : 0;
        t1 = (rn == 2) ? inflight[1] : 0;
        drive(n, v0, v1, rn, t0, t1, rec);
        #1;
        chk({tag, "_count"}, fl_count, fq.size());
        chk({tag, "_avail"}, fl_avail_num, (fq.size() >= 2) ? 2 : fq.size());
        chk({tag, "_err"}, fl_error, 0);
        if (fq.size() >= 1) chk({tag, "_pr0"}, fl_pr0, fq[0]);
        if (v0 && fq.size() >= 2) chk({tag, "_pr1"}, fl_pr1, fq[1]);
        else if (!v0 && fq.size() >= 1) chk({tag, "_pr1"}, fl_pr1, fq[0]);
        tick();
        if (rec) begin
            fq = {inflight, fq};
            inflight.delete();
        end else begin
            for (int k = 0; k < rn; k++) void'(inflight.pop_front());
            for (int k = 0; k < pop; k++) inflight.push_back(fq.pop_front());
            if (rn >= 1) fq.push_back(t0);
            if (rn == 2) fq.push_back(t1);
        end
    endtask

    vec_t vecs[8];

    initial begin
        // Directed table from reset: 3x dual dispatch, slot-1-only dispatch,
        // retire of 5/7, then recover back to the retire point.
        vecs[0] = '{2,1,1, 0,0,0, 0, 32,33,2,96};
        vecs[1] = '{2,1,1, 0,0,0, 0, 34,35,2,94};
        vecs[2] = '{2,1,1, 0,0,0, 0, 36,37,2,92};
        vecs[3] = '{2,0,1, 0,0,0, 0, 38,38,2,90};
        vecs[4] = '{0,0,0, 0,0,0, 0, 39,39,2,89};
        vecs[5] = '{0,0,0, 2,5,7, 0, 39,39,2,89};
        vecs[6] = '{0,0,0, 0,0,0, 1, 39,39,2,91};
        vecs[7] = '{0,1,0, 0,0,0, 0, 34,35,2,96};

        @(negedge clock);
        do_reset();
        #1;
        chk("rst_pr0", fl_pr0, 32);
        chk("rst_pr1", fl_pr1, 33);
        chk("rst_avail", fl_avail_num, 2);
        chk("rst_count", fl_count, 96);
        chk("rst_err", fl_error, 0);
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].n, vecs[i].v0, vecs[i].v1, vecs[i].rn,
                  vecs[i].t0, vecs[i].t1, vecs[i].rec);
            #1;
            chk($sformatf("vec%0d_pr0", i), fl_pr0, vecs[i].e_pr0);
            chk($sformatf("vec%0d_pr1", i), fl_pr1, vecs[i].e_pr1);
            chk($sformatf("vec%0d_avail", i), fl_avail_num, vecs[i].e_avail);
            chk($sformatf("vec%0d_count", i), fl_count, vecs[i].e_count);
            tick();
        end
        chk("vec_err", fl_error, 0);

        // Allocate 6, retire 2, recover: head returns to 2.
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(2, 1, 1, 0, 0, 0, 0); tick(); end
        drive(0, 1, 0, 2, 5, 7, 0); tick();
        drive(0, 1, 0, 0, 0, 0, 1); tick();
        drive(0, 1, 0, 0, 0, 0, 0); #1;
        chk("rec_count", fl_count, 96);
        chk("rec_pr0", fl_pr0, 34);
        chk("rec_pr1", fl_pr1, 35);

        // Drain to 1, over-request, then push into an empty list.
        do_reset();
        for (int i = 0; i < 47; i++) begin drive(2, 1, 1, 0, 0, 0, 0); tick(); end
        drive(1, 1, 0, 0, 0, 0, 0); tick();
        drive(2, 1, 1, 0, 0, 0, 0); #1;
        chk("drain_count1", fl_count, 1);
        chk("drain_avail1", fl_avail_num, 1);
        chk("drain_pr0", fl_pr0, 127);
        chk("drain_err_before", fl_error, 0);
        tick();
        drive(0, 1, 0, 2, 10, 11, 0); #1;
        chk("empty_count", fl_count, 0);
        chk("empty_avail", fl_avail_num, 0);
        chk("underflow_err", fl_error, 1);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0); #1;
        chk("refill_avail", fl_avail_num, 2);
        chk("refill_count", fl_count, 2);
        chk("refill_pr0", fl_pr0, 10);
        chk("refill_pr1", fl_pr1, 11);
        chk("err_sticky", fl_error, 1);

        // Fill to 128, then an extra return must be dropped.
        do_reset();
        for (int i = 0; i < 16; i++) begin drive(0, 1, 0, 2, 85, 85, 0); tick(); end
        drive(0, 1, 0, 1, 3, 0, 0); #1;
        chk("full_count", fl_count, 128);
        chk("full_err_before", fl_error, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0); #1;
        chk("ovf_count", fl_count, 128);
        chk("ovf_err", fl_error, 1);

        // Randomized traffic against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            int n, rn;
            bit v0, v1, rec;
            n   = $urandom_range(0, 2);
            v0  = 1'($urandom);
            v1  = 1'($urandom);
            rn  = $urandom_range(0, (inflight.size() < 2) ? inflight.size() : 2);
            rec = ($urandom_range(0, 19) == 0);
            if ((((n >= 1 && v0) ? 1 : 0) + ((n == 2 && v1) ? 1 : 0)) > fq.size()) n = 0;
            model_cycle(n, v0, v1, rn, rec, "rand");
        end

        // Balanced 2-in/2-out traffic long enough to wrap every pointer.
        do_reset();
        model_reset();
        for (int c = 0; c < 200; c++)
            model_cycle(2, 1, 1, (inflight.size() < 2) ? inflight.size() : 2, 0, "bal");
        #1;
        chk("bal_count", fl_count, 94);
        chk("bal_err", fl_error, 0);
        @(negedge clock);

        // Reset wins over concurrent dispatch, retire and recover.
        for (int i = 0; i < 5; i++) begin drive(2, 1, 1, 2, 1, 2, 0); tick(); end
        reset = 1'b1;
        drive(2, 1, 1, 2, 9, 9, 1);
        tick();
        reset = 1'b0;
        drive(0, 1, 0, 0, 0, 0, 0); #1;
        chk("midrst_pr0", fl_pr0, 32);
        chk("midrst_pr1", fl_pr1, 33);
        chk("midrst_avail", fl_avail_num, 2);
        chk("midrst_count", fl_count, 96);
        chk("midrst_err", fl_error, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/pr_free_list.md
PR_FREE_LIST -- requirements
Module: pr_free_list

Interface
REQ-001 clock  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-003 id_dispatch_num  in  2  instructions dispatched this cycle (0..2).
REQ-004 id_valid_inst0  in  1  slot-0 instruction valid.
REQ-005 id_valid_inst1  in  1  slot-1 instruction valid.
REQ-006 rob_retire_num  in  2  instructions retired this cycle (0..2).
REQ-007 rob_retire_told0  in  7  Told of retiring instruction 0, returned to the free list.
REQ-008 rob_retire_told1  in  7  Told of retiring instruction 1.
REQ-009 recover  in  1  mispredict recovery; discard all speculative allocations.
REQ-010 fl_pr0  out  7  PR tag offered to slot 0.
REQ-011 fl_pr1  out  7  PR tag offered to slot 1.
REQ-012 fl_avail_num  out  2  free PRs available this cycle, min(count,2); used by dispatch to stall.
REQ-013 fl_count  out  8  current free-list occupancy (0..128).
REQ-014 fl_error  out  1  sticky: set on over-allocation or overflow; cleared only by reset.

Function
REQ-015 Storage SHALL be a 128-entry circular buffer of 7-bit PR tags, with 7-bit head, tail and retire_head pointers wrapping modulo 128, plus an 8-bit count.
REQ-016 Allocation count SHALL be pop = (id_dispatch_num>=1 && id_valid_inst0) + (id_dispatch_num==2 && id_valid_inst1).
REQ-017 fl_pr0 SHALL equal buf[head]; fl_pr1 SHALL equal buf[head+1] when id_valid_inst0, else buf[head] (combinational, zero latency).
REQ-018 Each cycle without recover: head += pop, tail += push, retire_head += rob_retire_num, count += push - pop, all registered at the next edge.
REQ-019 Retire push SHALL write rob_retire_told0 at buf[tail] when rob_retire_num>=1, and rob_retire_told1 at buf[tail+1] when rob_retire_num==2; push = rob_retire_num.
REQ-020 Freed tags SHALL NOT be visible to allocation in the same cycle; they are offered no earlier than the next cycle, so with count==0 fl_avail_num==0 even when pushing.
REQ-021 Simultaneous pop and push in one cycle SHALL both take effect, with the net count update.
REQ-022 If pop > count: pop SHALL be clamped to count, and fl_error SHALL be set.
REQ-023 If count + push - pop > 128: the push SHALL be dropped, and fl_error SHALL be set.
REQ-024 On recover: head <= retire_head and count <= 96; dispatch and retire inputs in that cycle SHALL be ignored; tail and buffer contents SHALL be unchanged.
REQ-025 Wrap-around: pointer arithmetic SHALL be modulo 128 with no bubble; head+1 at head==127 addresses entry 0.
REQ-026 Invariant (checked by verification): tail - retire_head (mod 128) == 96 whenever fl_error==0, except in the reset-value state.

Reset
REQ-027 On reset: buf[i] = 32+i for i=0..95 (entries 96..127 don't-care); head=0, retire_head=0, tail=96 (mod 128), count=96.
REQ-028 Reset outputs SHALL be fl_pr0=32, fl_pr1=33, fl_avail_num=2, fl_count=96, fl_error=0.
REQ-029 Reset SHALL override recover, dispatch and retire in the same cycle, including reset asserted mid-operation.

Verification
REQ-030 Reset, then dispatch 2 valid instructions for 3 cycles -> fl_pr0/fl_pr1 = 32/33, 34/35, 36/37; fl_count = 94, 92, 90.
REQ-031 Dispatch with id_valid_inst0=0, id_valid_inst1=1, num=2 -> fl_pr1 = buf[head]; pop=1; count decreases by 1.
REQ-032 Drain count to 1, then request 2 -> fl_avail_num=1, one tag popped, fl_error=1; count=0 with push 2 in the same cycle -> fl_avail_num=0 that cycle, 2 the next.
REQ-033 Allocate 6, retire 2 (told 5,7), then recover -> head = 2, count = 96, and the next fl_pr0 = 34.
REQ-034 Run 200 cycles of balanced 2-pop/2-push traffic -> pointers wrap past 127, tags are returned in FIFO order, count is stable, fl_error=0.
REQ-035 Assert reset during concurrent dispatch, retire and recover -> all REQ-028 values on the next cycle.
